// File: rtl/ov5640_seq_ctrl.sv
// OV5640 bring-up and capture sequencer: sensor reset, SCCB config start, frame-aligned
// gating of the AXI4-Stream converter, watchdog-driven retries and status reporting.
module ov5640_seq_ctrl #(
   parameter int unsigned RESET_CYCLES  = 1000,
   parameter int unsigned WAIT_CYCLES   = 20000,
   parameter int unsigned CFG_TIMEOUT   = 1000000,
   parameter int unsigned FRAME_TIMEOUT = 4000000,
   parameter int unsigned MAX_RETRY     = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        capture_en,
   input  logic        soft_restart,
   input  logic        cfg_done,
   input  logic        cmos_vsync,
   output logic        cmos_reset,
   output logic        cfg_start,
   output logic        axis_enable,
   output logic [2:0]  state,
   output logic [15:0] frame_cnt,
   output logic [1:0]  retry_cnt,
   output logic        error
);

   typedef enum logic [2:0] {
      StReset  = 3'd0,
      StWait   = 3'd1,
      StConfig = 3'd2,
      StArm    = 3'd3,
      StStream = 3'd4,
      StDrain  = 3'd5,
      StError  = 3'd6,
      StFail   = 3'd7
   } state_e;

   localparam logic [23:0] ResetLast = 24'(RESET_CYCLES - 1);
   localparam logic [23:0] WaitLast  = 24'(WAIT_CYCLES - 1);
   localparam logic [23:0] CfgLast   = 24'(CFG_TIMEOUT - 1);
   localparam logic [23:0] FrameLast = 24'(FRAME_TIMEOUT - 1);

   state_e      state_q, state_d;
   logic [23:0] cnt_q, cnt_d;
   logic [15:0] frame_cnt_q, frame_cnt_d;
   logic [1:0]  retry_cnt_q, retry_cnt_d;
   logic        error_q, error_d;
   logic        cmos_reset_q, cmos_reset_d;
   logic        cfg_start_q, cfg_start_d;
   logic        axis_enable_q, axis_enable_d;
   logic        cfg_meta_q, cfg_sync_q;
   logic        vs_meta_q, vs_sync_q, vs_last_q;
   logic        sof_q, sof_d, eof_q, eof_d;

   // Edge pulses are registered, so the FSM sees them 3 cycles after the vsync pin moves.
   always_comb begin
      sof_d = vs_last_q & ~vs_sync_q;
      eof_d = ~vs_last_q & vs_sync_q;
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q + 24'd1;
      frame_cnt_d = frame_cnt_q;
      retry_cnt_d = retry_cnt_q;
      error_d     = error_q;

      case (state_q)
         StReset: if (cnt_q == ResetLast) state_d = StWait;
         StWait:  if (cnt_q == WaitLast) state_d = StConfig;
         StConfig: begin
            if (cnt_q == CfgLast) state_d = StError;
            else if (cfg_sync_q) state_d = StArm;
         end
         StArm: begin
            if (capture_en && sof_q) begin
               state_d     = StStream;
               frame_cnt_d = frame_cnt_q + 16'd1;
            end
         end
         StStream: begin
            if (cnt_q == FrameLast) begin
               state_d = StError;
            end else begin
               if (sof_q) frame_cnt_d = frame_cnt_q + 16'd1;
               if (sof_q || eof_q) cnt_d = '0;
               if (!capture_en) state_d = StDrain;
            end
         end
         StDrain: begin
            if (cnt_q == FrameLast) begin
               state_d = StError;
            end else begin
               if (sof_q || eof_q) cnt_d = '0;
               if (eof_q) state_d = StArm;
            end
         end
         StError: begin
            if (32'(retry_cnt_q) < MAX_RETRY) begin
               retry_cnt_d = retry_cnt_q + 2'd1;
               state_d     = StReset;
            end else begin
               state_d = StFail;
            end
         end
         StFail:  cnt_d = '0;
         default: state_d = StReset;
      endcase

      if (state_d != state_q) cnt_d = '0;
      if (state_d == StError) error_d = 1'b1;
      // An automatic retry is a fresh bring-up, so the admitted-frame count restarts too.
      if (state_q == StError && state_d == StReset) frame_cnt_d = '0;

      if (soft_restart) begin
         state_d     = StReset;
         cnt_d       = '0;
         frame_cnt_d = '0;
         retry_cnt_d = '0;
         error_d     = 1'b0;
      end

      cmos_reset_d  = !(state_d == StReset || state_d == StFail);
      cfg_start_d   = (state_d == StConfig) && (state_q != StConfig);
      axis_enable_d = (state_d == StStream) || (state_d == StDrain);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= StReset;
         cnt_q         <= '0;
         frame_cnt_q   <= '0;
         retry_cnt_q   <= '0;
         error_q       <= 1'b0;
         cmos_reset_q  <= 1'b0;
         cfg_start_q   <= 1'b0;
         axis_enable_q <= 1'b0;
         cfg_meta_q    <= 1'b0;
         cfg_sync_q    <= 1'b0;
         vs_meta_q     <= 1'b0;
         vs_sync_q     <= 1'b0;
         vs_last_q     <= 1'b0;
         sof_q         <= 1'b0;
         eof_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         frame_cnt_q   <= frame_cnt_d;
         retry_cnt_q   <= retry_cnt_d;
         error_q       <= error_d;
         cmos_reset_q  <= cmos_reset_d;
         cfg_start_q   <= cfg_start_d;
         axis_enable_q <= axis_enable_d;
         cfg_meta_q    <= cfg_done;
         cfg_sync_q    <= cfg_meta_q;
         vs_meta_q     <= cmos_vsync;
         vs_sync_q     <= vs_meta_q;
         vs_last_q     <= vs_sync_q;
         sof_q         <= sof_d;
         eof_q         <= eof_d;
      end
   end

   assign cmos_reset  = cmos_reset_q;
   assign cfg_start   = cfg_start_q;
   assign axis_enable = axis_enable_q;
   assign state       = state_q;
   assign frame_cnt   = frame_cnt_q;
   assign retry_cnt   = retry_cnt_q;
   assign error       = error_q;

endmodule

// File: tb/tb_ov5640_seq_ctrl.sv
// Directed bench for ov5640_seq_ctrl: bring-up timing, frame gating, timeouts/retries,
// soft restart, frame counter wrap and asynchronous reset.
module tb_ov5640_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        capture_en;
   logic        soft_restart;
   logic        cfg_done;
   logic        cmos_vsync;
   logic        cmos_reset;
   logic        cfg_start;
   logic        axis_enable;
   logic [2:0]  state;
   logic [15:0] frame_cnt;
   logic [1:0]  retry_cnt;
   logic        error;

   int n_tests = 0;
   int n_fail  = 0;

   ov5640_seq_ctrl #(
      .RESET_CYCLES  (10),
      .WAIT_CYCLES   (20),
      .CFG_TIMEOUT   (100),
      .FRAME_TIMEOUT (500),
      .MAX_RETRY     (3)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .capture_en   (capture_en),
      .soft_restart (soft_restart),
      .cfg_done     (cfg_done),
      .cmos_vsync   (cmos_vsync),
      .cmos_reset   (cmos_reset),
      .cfg_start    (cfg_start),
      .axis_enable  (axis_enable),
      .state        (state),
      .frame_cnt    (frame_cnt),
      .retry_cnt    (retry_cnt),
      .error        (error)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] probe(input int which);
      case (which)
         0:       return {29'd0, state};
         1:       return {31'd0, axis_enable};
         2:       return {31'd0, cmos_reset};
         default: return {31'd0, cfg_start};
      endcase
   endfunction

   // Counts rising edges until the probed signal equals val, giving up after limit edges.
   task automatic count_edges(input int which, input logic [31:0] val, input int limit,
                              output int k);
      k = 0;
      while (probe(which) !== val && k < limit) begin
         @(posedge clk);
         #1;
         k++;
      end
   endtask

   task automatic vsync_pulse();
      @(negedge clk) cmos_vsync = 1'b1;
      repeat (4) @(negedge clk);
      cmos_vsync = 1'b0;
   endtask

   initial begin
      int k;
      int k2;
      rst          = 1'b1;
      capture_en   = 1'b0;
      soft_restart = 1'b0;
      cfg_done     = 1'b0;
      cmos_vsync   = 1'b0;
      repeat (3) @(negedge clk);

      check("rst_state", {29'd0, state}, 32'd0);
      check("rst_cmos_reset", {31'd0, cmos_reset}, 32'd0);
      check("rst_cfg_start", {31'd0, cfg_start}, 32'd0);
      check("rst_axis", {31'd0, axis_enable}, 32'd0);
      check("rst_frame", {16'd0, frame_cnt}, 32'd0);
      check("rst_retry", {30'd0, retry_cnt}, 32'd0);
      check("rst_error", {31'd0, error}, 32'd0);

      // Bring-up timing
      rst = 1'b0;
      count_edges(2, 32'd1, 100, k);
      check("cmos_reset_low_cycles", k, 32'd10);
      count_edges(3, 32'd1, 100, k2);
      check("cfg_start_cycle", k + k2, 32'd30);
      check("config_state", {29'd0, state}, 32'd2);
      @(posedge clk); #1;
      check("cfg_start_one_cycle", {31'd0, cfg_start}, 32'd0);
      repeat (48) @(posedge clk);
      @(negedge clk) cfg_done = 1'b1;
      check("still_config", {29'd0, state}, 32'd2);
      count_edges(0, 32'd3, 20, k);
      check("arm_latency", k, 32'd3);

      // Frame-aligned start and stop
      @(negedge clk) capture_en = 1'b1;
      repeat (5) @(negedge clk);
      check("arm_hold", {29'd0, state}, 32'd3);
      check("arm_axis_off", {31'd0, axis_enable}, 32'd0);
      vsync_pulse();
      count_edges(1, 32'd1, 20, k);
      check("axis_rise_latency", k, 32'd4);
      check("stream_state", {29'd0, state}, 32'd4);
      check("frame_cnt_1", {16'd0, frame_cnt}, 32'd1);
      repeat (20) @(negedge clk);
      vsync_pulse();
      repeat (20) @(negedge clk);
      check("frame_cnt_2", {16'd0, frame_cnt}, 32'd2);
      vsync_pulse();
      repeat (10) @(negedge clk);
      capture_en = 1'b0;
      @(posedge clk); #1;
      check("drain_state", {29'd0, state}, 32'd5);
      check("drain_axis_on", {31'd0, axis_enable}, 32'd1);
      check("frame_cnt_3", {16'd0, frame_cnt}, 32'd3);
      repeat (10) @(negedge clk);
      cmos_vsync = 1'b1;
      count_edges(1, 32'd0, 20, k);
      check("axis_fall_latency", k, 32'd4);
      check("back_to_arm", {29'd0, state}, 32'd3);
      @(negedge clk) cmos_vsync = 1'b0;
      repeat (8) @(negedge clk);
      check("arm_no_capture", {29'd0, state}, 32'd3);
      check("frame_cnt_held", {16'd0, frame_cnt}, 32'd3);

      // Frame watchdog
      @(negedge clk) capture_en = 1'b1;
      vsync_pulse();
      count_edges(1, 32'd1, 20, k);
      check("wd_stream_entry", k, 32'd4);
      count_edges(0, 32'd6, 700, k);
      check("wd_timeout_cycles", k, 32'd500);
      check("wd_axis_off", {31'd0, axis_enable}, 32'd0);
      check("wd_error", {31'd0, error}, 32'd1);
      check("wd_retry_in_error", {30'd0, retry_cnt}, 32'd0);
      @(posedge clk); #1;
      check("wd_reset_next", {29'd0, state}, 32'd0);
      check("wd_retry", {30'd0, retry_cnt}, 32'd1);
      count_edges(0, 32'd3, 100, k);
      check("cfg_done_level_accept", k, 32'd31);
      check("error_sticky", {31'd0, error}, 32'd1);

      // soft_restart from STREAM
      vsync_pulse();
      count_edges(1, 32'd1, 20, k);
      check("sr_stream_entry", {29'd0, state}, 32'd4);
      @(negedge clk) soft_restart = 1'b1;
      @(posedge clk); #1;
      check("sr_stream_state", {29'd0, state}, 32'd0);
      check("sr_stream_error", {31'd0, error}, 32'd0);
      check("sr_stream_retry", {30'd0, retry_cnt}, 32'd0);
      check("sr_stream_frame", {16'd0, frame_cnt}, 32'd0);
      check("sr_stream_axis", {31'd0, axis_enable}, 32'd0);
      @(negedge clk) soft_restart = 1'b0;

      // Frame counter wrap with sof and capture_en falling together
      count_edges(0, 32'd3, 100, k);
      check("wrap_arm", k, 32'd31);
      vsync_pulse();
      count_edges(1, 32'd1, 20, k);
      check("wrap_frame_1", {16'd0, frame_cnt}, 32'd1);
      @(negedge clk);
      force dut.frame_cnt_q = 16'hffff;
      @(posedge clk);
      @(negedge clk);
      release dut.frame_cnt_q;
      #1;
      check("wrap_preload", {16'd0, frame_cnt}, 32'h0000ffff);
      vsync_pulse();
      repeat (3) @(negedge clk);
      capture_en = 1'b0;
      @(posedge clk); #1;
      check("wrap_frame_0", {16'd0, frame_cnt}, 32'd0);
      check("wrap_drain", {29'd0, state}, 32'd5);
      @(negedge clk) cmos_vsync = 1'b1;
      count_edges(1, 32'd0, 20, k);
      check("wrap_drain_exit", k, 32'd4);

      // Configuration timeout and retries
      @(negedge clk);
      cfg_done     = 1'b0;
      soft_restart = 1'b1;
      @(negedge clk) soft_restart = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         count_edges(3, 32'd1, 300, k);
         count_edges(0, 32'd6, 300, k);
         check($sformatf("cfg_timeout_cycles_%0d", i), k, 32'd100);
         check($sformatf("cfg_timeout_error_%0d", i), {31'd0, error}, 32'd1);
         check($sformatf("cfg_retry_in_error_%0d", i), {30'd0, retry_cnt}, 32'(i - 1));
         @(posedge clk); #1;
         if (i < 4) begin
            check($sformatf("retry_reset_%0d", i), {29'd0, state}, 32'd0);
            check($sformatf("retry_cnt_%0d", i), {30'd0, retry_cnt}, 32'(i));
         end else begin
            check("fail_state", {29'd0, state}, 32'd7);
            check("fail_cmos_reset", {31'd0, cmos_reset}, 32'd0);
            check("fail_retry", {30'd0, retry_cnt}, 32'd3);
         end
      end
      repeat (50) @(negedge clk);
      check("fail_terminal", {29'd0, state}, 32'd7);
      check("fail_cmos_reset_held", {31'd0, cmos_reset}, 32'd0);

      // soft_restart from FAIL
      soft_restart = 1'b1;
      @(posedge clk); #1;
      check("sr_fail_state", {29'd0, state}, 32'd0);
      check("sr_fail_error", {31'd0, error}, 32'd0);
      check("sr_fail_retry", {30'd0, retry_cnt}, 32'd0);
      check("sr_fail_frame", {16'd0, frame_cnt}, 32'd0);
      check("sr_fail_axis", {31'd0, axis_enable}, 32'd0);
      @(negedge clk);
      soft_restart = 1'b0;
      cfg_done     = 1'b1;

      // Asynchronous reset while streaming
      count_edges(0, 32'd3, 100, k);
      check("async_arm", {29'd0, state}, 32'd3);
      @(negedge clk) capture_en = 1'b1;
      vsync_pulse();
      count_edges(1, 32'd1, 20, k);
      check("async_stream", {29'd0, state}, 32'd4);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check("async_axis", {31'd0, axis_enable}, 32'd0);
      check("async_state", {29'd0, state}, 32'd0);
      check("async_cmos_reset", {31'd0, cmos_reset}, 32'd0);
      @(negedge clk) rst = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
